cnt_sn_updown: RTL and testbench
================================

// Module: cnt_sn_updown
// PURPOSE
//  Parametrised signed up/down counter that runs between MIN and MAX with a
//  selectable step. End-of-range handling is chosen at build time: wrap or saturate.
//  Supports synchronous clear and load, plus a legacy "en low forces zero" mode.
//  Supplies signed sequence/address values to the lab datapath blocks.
//  The default build replaces the fixed 5-bit -8..7 counter.
// PARAMETERS
//  WIDTH    5   counter width, two's complement, 3..16
//  MIN     -8   lowest count value (signed, must fit WIDTH, MIN <= 0)
//  MAX      7   highest count value (signed, must fit WIDTH, MAX >= 0, MAX > MIN)
//  RST_VAL -8   value loaded by reset (MIN <= RST_VAL <= MAX)
//  SAT      0   0: modular wrap within [MIN,MAX]; 1: saturate at MIN/MAX
//  EN_CLR   1   1: en=0 forces count to 0 (legacy); 0: en=0 holds count
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous reset, active-low (0 = reset)
//  en        in   1      count enable
//  up        in   1      direction: 1 = add step, 0 = subtract step
//  step      in   WIDTH  unsigned step magnitude, 0..(MAX-MIN+1)
//  clr       in   1      synchronous clear to 0
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  signed load value
//  out_num   out  WIDTH  signed count, registered
//  wrap      out  1      1-cycle pulse: last update crossed MAX/MIN (wrapped or clipped)
//  at_max    out  1      registered, out_num == MAX
//  at_min    out  1      registered, out_num == MIN
// BEHAVIOUR
//  - rst=0 (any time, asynchronous): out_num=RST_VAL, wrap=0,
//    at_max=(RST_VAL==MAX), at_min=(RST_VAL==MIN). Release is synchronous to clk.
//  - Priority per rising clk edge (rst=1): clr > load > en/EN_CLR > count.
//  - clr=1: out_num<=0, wrap<=0.
//  - load=1: out_num<=clamp(load_val,MIN,MAX), wrap<=0. Clamping is signed.
//  - en=0: if EN_CLR then out_num<=0, else hold. wrap<=0 in both cases.
//  - en=1: compute n = out_num +/- step in WIDTH+2 signed bits (no internal overflow).
//    - MIN <= n <= MAX: out_num<=n, wrap<=0.
//    - Up, n > MAX, SAT=0: out_num <= MIN + (n - MAX - 1), wrap<=1.
//    - Up, n > MAX, SAT=1: out_num <= MAX, wrap<=1.
//    - Down, n < MIN, SAT=0: out_num <= MAX - (MIN - n - 1), wrap<=1.
//    - Down, n < MIN, SAT=1: out_num <= MIN, wrap<=1.
//    - step=0: hold, wrap<=0.
//  - step > MAX-MIN+1 is illegal. The bench must flag it with an assertion; RTL
//    behaviour for this case is unspecified.
//  - Latency: one cycle from inputs to out_num, wrap, at_max and at_min.
//    at_max and at_min are derived from the next-state value, so they align with
//    out_num.
//  - Default build with SAT=0, EN_CLR=1, up=1, step=1 reproduces the legacy
//    counter exactly: reset -8, count to 7, then 0. The legacy design wraps 7->0
//    because of its explicit ==7 test. To keep that, MAX-wrap in the default build
//    goes to 0, not MIN: when WRAP_TO_ZERO (localparam = SAT==0 && EN_CLR==1) is set,
//    both wrap targets are 0.
//  - Asserting rst mid-count aborts the update; no partial state remains.
// TESTING
//  1 Default params, rst low 3 cycles, then en=1 up=1 step=1 for 20 cycles ->
//    -8,-7..7,0,1..; wrap=1 on the cycle out_num becomes 0 after 7.
//  2 SAT=1, out_num=5, up=1 step=4 -> out_num=7, wrap=1, at_max=1; next cycle
//    out_num stays 7.
//  3 SAT=0 EN_CLR=0, MIN=-8 MAX=7, out_num=-6, up=0 step=5 -> out_num=5, wrap=1.
//  4 load=1 load_val=-16 (WIDTH=6, MIN=-8) -> out_num=-8, at_min=1. With clr=1
//    and load=1 in the same cycle -> out_num=0.
//  5 EN_CLR=1, count at 4, en=0 -> out_num=0. EN_CLR=0, same stimulus ->
//    out_num holds 4.
//  6 Drive rst low asynchronously between edges while counting ->
//    out_num=RST_VAL immediately, wrap=0.

Source files
------------

// File: rtl/cnt_sn_updown.sv
`default_nettype none
// ============================================================================
// Module   : cnt_sn_updown
// Brief    : Signed up/down counter over [MIN,MAX] with selectable step,
//            wrap or saturate end handling, clear/load and legacy en-clear.
// Revision : 1.0 - initial release
// ============================================================================
module cnt_sn_updown #(
    parameter int WIDTH   = 5,
    parameter int MIN     = -8,
    parameter int MAX     = 7,
    parameter int RST_VAL = -8,
    parameter int SAT     = 0,
    parameter int EN_CLR  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up,
    input  logic        [WIDTH-1:0] step,
    input  logic                    clr,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] load_val,
    output logic signed [WIDTH-1:0] out_num,
    output logic                    wrap,
    output logic                    at_max,
    output logic                    at_min
);

    localparam int XW = WIDTH + 2;
    localparam logic signed [XW-1:0] C_MIN_X = XW'(MIN);
    localparam logic signed [XW-1:0] C_MAX_X = XW'(MAX);
    localparam logic signed [XW-1:0] C_RST_X = XW'(RST_VAL);
    localparam logic signed [XW-1:0] C_ONE_X = XW'(1);
    // The legacy build wraps 7 -> 0, so both wrap bases collapse to zero there.
    localparam logic                 WRAP_TO_ZERO = (SAT == 0) && (EN_CLR == 1);
    localparam logic signed [XW-1:0] C_HI_BASE = WRAP_TO_ZERO ? '0 : C_MIN_X;
    localparam logic signed [XW-1:0] C_LO_BASE = WRAP_TO_ZERO ? '0 : C_MAX_X;

    logic signed [WIDTH-1:0] out_num_q, out_num_d;
    logic                    wrap_q, wrap_d;
    logic                    at_max_q, at_max_d;
    logic                    at_min_q, at_min_d;

    logic signed [XW-1:0] cur_x, step_x, n_x, lv_x, res_x;

    always_comb begin
        cur_x  = XW'(out_num_q);
        step_x = $signed({2'b00, step});
        n_x    = up ? (cur_x + step_x) : (cur_x - step_x);
        lv_x   = XW'(load_val);
        res_x  = cur_x;
        wrap_d = 1'b0;
        if (clr) begin
            res_x = '0;
        end else if (load) begin
            if (lv_x > C_MAX_X)
                res_x = C_MAX_X;
            else if (lv_x < C_MIN_X)
                res_x = C_MIN_X;
            else
                res_x = lv_x;
        end else if (!en) begin
            if (EN_CLR != 0)
                res_x = '0;
        end else if (step != '0) begin
            if (n_x > C_MAX_X) begin
                wrap_d = 1'b1;
                res_x  = (SAT != 0) ? C_MAX_X : (C_HI_BASE + (n_x - C_MAX_X - C_ONE_X));
            end else if (n_x < C_MIN_X) begin
                wrap_d = 1'b1;
                res_x  = (SAT != 0) ? C_MIN_X : (C_LO_BASE - (C_MIN_X - n_x - C_ONE_X));
            end else begin
                res_x = n_x;
            end
        end
        out_num_d = res_x[WIDTH-1:0];
        at_max_d  = (res_x == C_MAX_X);
        at_min_d  = (res_x == C_MIN_X);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_num_q <= C_RST_X[WIDTH-1:0];
            wrap_q    <= 1'b0;
            at_max_q  <= (C_RST_X == C_MAX_X);
            at_min_q  <= (C_RST_X == C_MIN_X);
        end else begin
            out_num_q <= out_num_d;
            wrap_q    <= wrap_d;
            at_max_q  <= at_max_d;
            at_min_q  <= at_min_d;
        end
    end

    assign out_num = out_num_q;
    assign wrap    = wrap_q;
    assign at_max  = at_max_q;
    assign at_min  = at_min_q;

endmodule
`default_nettype wire

// File: tb/tb_cnt_sn_updown.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_sn_updown
// Brief    : Directed bench for cnt_sn_updown across four parameter builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_sn_updown;

    logic              clk = 1'b0;
    logic              rst;
    logic              en, up, clr, load;
    logic        [5:0] step6;
    logic signed [5:0] lv6;

    logic signed [4:0] def_out, sat_out, wrp_out;
    logic signed [5:0] w6_out;
    logic def_wrap, def_max, def_min;
    logic sat_wrap, sat_max, sat_min;
    logic wrp_wrap, wrp_max, wrp_min;
    logic w6_wrap, w6_max, w6_min;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cnt_sn_updown u_def (
        .clk(clk), .rst(rst), .en(en), .up(up), .step(step6[4:0]), .clr(clr),
        .load(load), .load_val(lv6[4:0]), .out_num(def_out), .wrap(def_wrap),
        .at_max(def_max), .at_min(def_min));

    cnt_sn_updown #(.SAT(1), .EN_CLR(0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .step(step6[4:0]), .clr(clr),
        .load(load), .load_val(lv6[4:0]), .out_num(sat_out), .wrap(sat_wrap),
        .at_max(sat_max), .at_min(sat_min));

    cnt_sn_updown #(.SAT(0), .EN_CLR(0)) u_wrp (
        .clk(clk), .rst(rst), .en(en), .up(up), .step(step6[4:0]), .clr(clr),
        .load(load), .load_val(lv6[4:0]), .out_num(wrp_out), .wrap(wrp_wrap),
        .at_max(wrp_max), .at_min(wrp_min));

    cnt_sn_updown #(.WIDTH(6)) u_w6 (
        .clk(clk), .rst(rst), .en(en), .up(up), .step(step6), .clr(clr),
        .load(load), .load_val(lv6), .out_num(w6_out), .wrap(w6_wrap),
        .at_max(w6_max), .at_min(w6_min));

    // Steps beyond the full range (16) are illegal for every build here.
    always @(posedge clk) begin
        if (rst && en && !clr && !load)
            assert (step6 <= 6'd16) else $error("illegal step %0d", step6);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        load = 1'b1;
        lv6  = 6'(v);
        tick();
        load = 1'b0;
    endtask

    initial begin
        int exp_def, exp_wrp;
        rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
        step6 = 6'd1; lv6 = '0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_out", int'(def_out), -8);
        check_eq("rst_wrap", int'(def_wrap), 0);
        check_eq("rst_min", int'(def_min), 1);
        check_eq("rst_max", int'(def_max), 0);
        rst = 1'b1;

        // Legacy count: -8..7 then 0 in the default build, -8 in the plain-wrap build
        en = 1'b1; up = 1'b1; step6 = 6'd1;
        exp_def = -8;
        exp_wrp = -8;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("cnt_wrap", int'(def_wrap), (exp_def == 7) ? 1 : 0);
            exp_def = (exp_def == 7) ? 0 : exp_def + 1;
            exp_wrp = (exp_wrp == 7) ? -8 : exp_wrp + 1;
            check_eq("cnt_out", int'(def_out), exp_def);
            check_eq("cnt_max", int'(def_max), (exp_def == 7) ? 1 : 0);
            check_eq("wrp_cnt", int'(wrp_out), exp_wrp);
        end

        // Saturate up from 5 by 4
        do_load(5);
        check_eq("ld5", int'(sat_out), 5);
        check_eq("ld5_wrap", int'(sat_wrap), 0);
        up = 1'b1; step6 = 6'd4;
        tick();
        check_eq("sat_up", int'(sat_out), 7);
        check_eq("sat_up_wrap", int'(sat_wrap), 1);
        check_eq("sat_up_max", int'(sat_max), 1);
        tick();
        check_eq("sat_hold", int'(sat_out), 7);

        // Wrap down from -6 by 5
        do_load(-6);
        check_eq("ldm6", int'(wrp_out), -6);
        up = 1'b0; step6 = 6'd5;
        tick();
        check_eq("wrp_dn", int'(wrp_out), 5);
        check_eq("wrp_dn_wrap", int'(wrp_wrap), 1);
        check_eq("sat_dn", int'(sat_out), -8);
        check_eq("sat_dn_min", int'(sat_min), 1);

        // Step zero holds
        step6 = 6'd0;
        tick();
        check_eq("step0", int'(wrp_out), 5);
        check_eq("step0_wrap", int'(wrp_wrap), 0);

        // Signed load clamp and clr over load
        do_load(-16);
        check_eq("w6_clamp", int'(w6_out), -8);
        check_eq("w6_clamp_min", int'(w6_min), 1);
        load = 1'b1; clr = 1'b1; lv6 = 6'sd3;
        tick();
        load = 1'b0; clr = 1'b0;
        check_eq("clr_pri", int'(w6_out), 0);
        check_eq("clr_pri_min", int'(w6_min), 0);
        do_load(20);
        check_eq("w6_clamp_hi", int'(w6_out), 7);

        // en low: clear in legacy mode, hold otherwise
        do_load(4);
        en = 1'b0;
        tick();
        check_eq("enclr", int'(def_out), 0);
        check_eq("enhold", int'(sat_out), 4);

        // Async reset between edges aborts a wrapping update
        do_load(7);
        en = 1'b1; up = 1'b1; step6 = 6'd1;
        tick();
        check_eq("pre_rst_wrap", int'(def_wrap), 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_out", int'(def_out), -8);
        check_eq("async_wrap", int'(def_wrap), 0);
        check_eq("async_sat", int'(sat_out), -8);
        tick();
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
